// File: rtl/hazard_pkg.sv
// Shared types and constants for the ARM/RISC-V pipeline hazard controller.
// Holds the FSM state encoding, forward-select codes and reserved-register addresses.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    SWITCH
  } hz_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [4:0] RZ_RISCV = 5'd0;
  localparam logic [4:0] RZ_ARM   = 5'd15;

  // Under ARM r15 reads as PC+8 from the register file, so it behaves like x0 for hazards.
  function automatic logic [4:0] rzAddr(input logic arm);
    return arm ? RZ_ARM : RZ_RISCV;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forward-source selection for a single execute-stage operand.
// Memory stage wins over writeback; the reserved register is never forwarded.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] i_rsE,
  input  logic [4:0] i_rdM,
  input  logic [4:0] i_rdW,
  input  logic       i_regWriteM,
  input  logic       i_regWriteW,
  input  logic [4:0] i_rz,
  output logic [1:0] o_fwd
);

  always_comb begin
    o_fwd = FWD_RF;
    if (i_rsE != i_rz) begin
      if (i_regWriteM && (i_rdM == i_rsE)) begin
        o_fwd = FWD_M;
      end else if (i_regWriteW && (i_rdW == i_rsE)) begin
        o_fwd = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control for the five-stage core, plus the ISA-mode
// register and the drain-then-toggle sequence for ISA-switch markers.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic        RESET_ARM    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       ResultSrcE0,
  input  logic       PCSrcE,
  input  logic       SwitchReqD,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       armD
);

  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

  hz_state_t  r_state;
  logic [2:0] r_cnt;
  logic       r_arm;

  logic [4:0] w_rz;
  logic       w_lwStall;

  assign w_rz      = rzAddr(r_arm);
  assign w_lwStall = ResultSrcE0 && ((Rs1D == RdE) || (Rs2D == RdE)) && (RdE != w_rz);
  assign armD      = r_arm;

  fwd_sel u_fwdA (
    .i_rsE       (Rs1E),
    .i_rdM       (RdM),
    .i_rdW       (RdW),
    .i_regWriteM (RegWriteM),
    .i_regWriteW (RegWriteW),
    .i_rz        (w_rz),
    .o_fwd       (ForwardAE)
  );

  fwd_sel u_fwdB (
    .i_rsE       (Rs2E),
    .i_rdM       (RdM),
    .i_rdW       (RdW),
    .i_regWriteM (RegWriteM),
    .i_regWriteW (RegWriteW),
    .i_rz        (w_rz),
    .o_fwd       (ForwardBE)
  );

  // A taken branch during DRAIN squashes the marker, so the switch is abandoned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= 3'd0;
      r_arm   <= RESET_ARM;
    end else begin
      case (r_state)
        RUN: begin
          if (SwitchReqD && !w_lwStall && !PCSrcE) begin
            r_state <= DRAIN;
            r_cnt   <= DRAIN_INIT;
          end
        end
        DRAIN: begin
          if (PCSrcE) begin
            r_state <= RUN;
          end else if (r_cnt == 3'd0) begin
            r_state <= SWITCH;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        SWITCH: begin
          r_arm   <= ~r_arm;
          r_state <= RUN;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    case (r_state)
      RUN: begin
        StallF = w_lwStall && !PCSrcE;
        StallD = w_lwStall && !PCSrcE;
        FlushE = w_lwStall || PCSrcE;
        FlushD = PCSrcE;
      end
      DRAIN: begin
        FlushE = 1'b1;
        if (PCSrcE) begin
          FlushD = 1'b1;
        end else begin
          StallF = 1'b1;
          StallD = 1'b1;
        end
      end
      SWITCH: begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
      default: begin
        FlushE = 1'b0;
      end
    endcase
  end

endmodule
